// File: rtl/handshake_skid_buffer_pkg.sv
// Shared types for the handshake skid buffer.
// State encoding and the default payload width.
package handshake_skid_buffer_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  function automatic logic state_has_skid(
    input state_e s
  );
    return s == FULL;
  endfunction

endpackage

// File: rtl/handshake_skid_buffer_reg_en.sv
// Enable-load register with async active-high clear.
// Holds its value whenever i_en is low.
module handshake_skid_buffer_reg_en #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/handshake_skid_buffer.sv
// Full-throughput valid/ready register slice with a one-entry skid slot.
// s_ready, m_valid and m_data all come straight from flops.
module handshake_skid_buffer
  import handshake_skid_buffer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  output logic             s_ready,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_m_valid;
  logic             r_skid_valid;
  logic             r_s_ready;

  logic             w_in;
  logic             w_out;
  logic             w_main_en;
  logic             w_main_sel_skid;
  logic             w_skid_en;
  logic [WIDTH-1:0] w_main_d;
  logic [WIDTH-1:0] w_main_q;
  logic [WIDTH-1:0] w_skid_q;

  assign w_in  = s_valid & r_s_ready;
  assign w_out = r_m_valid & m_ready;

  // s_ready stays low through reset and rises one edge after release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= EMPTY;
      r_m_valid    <= 1'b0;
      r_skid_valid <= 1'b0;
      r_s_ready    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_m_valid    <= (w_state_nxt != EMPTY);
      r_skid_valid <= state_has_skid(w_state_nxt);
      r_s_ready    <= !state_has_skid(w_state_nxt);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      EMPTY: begin
        if (w_in) w_state_nxt = ONE;
      end
      ONE: begin
        if (w_in && !w_out) begin
          w_state_nxt = FULL;
        end else if (!w_in && w_out) begin
          w_state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (w_out) w_state_nxt = ONE;
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    w_main_en       = 1'b0;
    w_main_sel_skid = 1'b0;
    w_skid_en       = 1'b0;
    unique case (1'b1)
      (r_state == EMPTY): begin
        w_main_en = w_in;
      end
      (r_state == ONE): begin
        w_main_en = w_in & w_out;
        w_skid_en = w_in & !w_out;
      end
      (r_state == FULL): begin
        w_main_en       = w_out;
        w_main_sel_skid = r_skid_valid;
      end
      default: begin
        w_main_en = 1'b0;
      end
    endcase
  end

  assign w_main_d = w_main_sel_skid ? w_skid_q : s_data;

  handshake_skid_buffer_reg_en #(
    .WIDTH(WIDTH)
  ) u_main (
    .i_clk(clk),
    .i_rst(rst),
    .i_en (w_main_en),
    .i_d  (w_main_d),
    .o_q  (w_main_q)
  );

  handshake_skid_buffer_reg_en #(
    .WIDTH(WIDTH)
  ) u_skid (
    .i_clk(clk),
    .i_rst(rst),
    .i_en (w_skid_en),
    .i_d  (s_data),
    .o_q  (w_skid_q)
  );

  assign s_ready = r_s_ready;
  assign m_valid = r_m_valid;
  assign m_data  = w_main_q;

endmodule

// File: tb/tb_handshake_skid_buffer.sv
// Directed bench for handshake_skid_buffer.
// Inputs change on falling edges; outputs are sampled there too.
module tb_handshake_skid_buffer;

  logic       clk;
  logic       rst;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready;

  int errors = 0;
  int checks = 0;

  logic [7:0] got_q[$];

  handshake_skid_buffer #(
    .WIDTH(8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .s_valid(s_valid),
    .s_data (s_data),
    .s_ready(s_ready),
    .m_valid(m_valid),
    .m_data (m_data),
    .m_ready(m_ready)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (!rst && m_valid && m_ready) got_q.push_back(m_data);
  end

  task automatic test_reset();
    rst = 1'b1;
    s_valid = 1'b0;
    s_data = 8'h00;
    m_ready = 1'b1;
    #1;
    checks++;
    if ({m_valid, m_data, s_ready} !== 10'h000) begin
      errors++;
      $display("FAIL reset_async: v=%b d=%h r=%b want 0 00 0",
               m_valid, m_data, s_ready);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({m_valid, m_data, s_ready} !== 10'h000) begin
      errors++;
      $display("FAIL reset_hold: v=%b d=%h r=%b want 0 00 0",
               m_valid, m_data, s_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: r=%b v=%b want 1 0",
               s_ready, m_valid);
    end
  endtask

  task automatic test_full_speed();
    s_valid = 1'b1;
    m_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      s_data = 8'(i);
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b1 || m_data !== 8'(i) || s_ready !== 1'b1) begin
        errors++;
        $display("FAIL full_speed[%0d]: v=%b d=%h r=%b want 1 %h 1",
                 i, m_valid, m_data, s_ready, 8'(i));
      end
    end
  endtask

  task automatic test_back_pressure();
    m_ready = 1'b0;
    s_data = 8'hFF;
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b1 || m_data !== 8'h03 || s_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall[%0d]: v=%b d=%h r=%b want 1 03 0",
                 i, m_valid, m_data, s_ready);
      end
    end
    checks++;
    if (dut.w_skid_q !== 8'hFF) begin
      errors++;
      $display("FAIL skid_capture: skid=%h want ff", dut.w_skid_q);
    end
  endtask

  task automatic test_recovery();
    m_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'hFF || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL recover_skid: v=%b d=%h r=%b want 1 ff 1",
               m_valid, m_data, s_ready);
    end
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'hFF) begin
      errors++;
      $display("FAIL recover_reaccept: v=%b d=%h want 1 ff",
               m_valid, m_data);
    end
    s_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL recover_empty: v=%b r=%b want 0 1",
               m_valid, s_ready);
    end
  endtask

  task automatic test_drain();
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data = 8'h10;
    @(negedge clk);
    s_data = 8'h20;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b0 || m_data !== 8'h10) begin
      errors++;
      $display("FAIL drain_full: r=%b d=%h want 0 10", s_ready, m_data);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h20 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL drain_second: v=%b d=%h r=%b want 1 20 1",
               m_valid, m_data, s_ready);
    end
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1 || m_data !== 8'h20) begin
      errors++;
      $display("FAIL drain_empty: v=%b r=%b d=%h want 0 1 20",
               m_valid, s_ready, m_data);
    end
  endtask

  task automatic test_async_reset_full();
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data = 8'h31;
    @(negedge clk);
    s_data = 8'h32;
    @(negedge clk);
    s_valid = 1'b0;
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h31 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL refill_full: v=%b d=%h r=%b want 1 31 0",
               m_valid, m_data, s_ready);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({m_valid, m_data, s_ready} !== 10'h000
        || dut.w_skid_q !== 8'h00) begin
      errors++;
      $display("FAIL async_clear: v=%b d=%h r=%b skid=%h want 0 00 0 00",
               m_valid, m_data, s_ready, dut.w_skid_q);
    end
    m_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL restart: r=%b v=%b want 1 0", s_ready, m_valid);
    end
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL discard: v=%b want 0", m_valid);
    end
  endtask

  task automatic test_ordering();
    logic [7:0] exp_seq [7];
    exp_seq = '{8'h01, 8'h02, 8'h03, 8'hFF, 8'hFF, 8'h10, 8'h20};
    checks++;
    if (got_q.size() !== 7) begin
      errors++;
      $display("FAIL delivery_count: got %0d want 7", got_q.size());
    end
    for (int i = 0; i < 7; i++) begin
      if (i < got_q.size()) begin
        checks++;
        if (got_q[i] !== exp_seq[i]) begin
          errors++;
          $display("FAIL order[%0d]: got %h want %h",
                   i, got_q[i], exp_seq[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_speed();
    test_back_pressure();
    test_recovery();
    test_drain();
    test_async_reset_full();
    test_ordering();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
